i2c_tgt2202: RTL and testbench

I2C_TGT2202 -- requirements
Module: i2c_tgt2202

---
 rtl/i2c_tgt_pkg.sv | 24 ++
 rtl/i2c_tgt_sync.sv | 62 ++++++
 rtl/i2c_tgt2202.sv | 192 +++++++++++++++++++
 tb/tb_i2c_tgt2202.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tgt_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, default
// target address and the byte returned when no transmit data is valid.
package i2c_tgt_pkg;

    localparam logic [6:0] DEFAULT_ADDR = 7'h42;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    // Byte placed on the bus for a read: user data when valid, else idle byte
    function automatic logic [7:0] tx_pick(input logic valid, input logic [7:0] data);
        return valid ? data : IDLE_BYTE;
    endfunction

endpackage

// File: rtl/i2c_tgt_sync.sv
// Bus front end: brings SCL/SDA into the clock domain and produces
// one-cycle START, STOP and SCL edge pulses plus the SDA value seen
// at the moment those pulses were generated.
module i2c_tgt_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_bit
);

    logic [1:0] scl_meta;
    logic [1:0] sda_meta;
    logic       scl_hist;
    logic       sda_hist;
    logic       scl_now;
    logic       sda_now;

    assign scl_now = scl_meta[1];
    assign sda_now = sda_meta[1];

    // Two-flop synchronisers followed by one history flop per line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: preset to 1 so that releasing reset on an idle bus
            // does not look like SDA falling while SCL is high.
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what gives a real shift chain.
            scl_meta <= {scl_meta[0], scl};
            sda_meta <= {sda_meta[0], sda};
            scl_hist <= scl_now;
            sda_hist <= sda_now;
        end
    end

    // Registered edge/condition pulses; sda_bit is the SDA level that goes with them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start    <= 1'b0;
            stop     <= 1'b0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_bit  <= 1'b1;
        end else begin
            start    <= scl_now & scl_hist & sda_hist & ~sda_now;
            stop     <= scl_now & scl_hist & ~sda_hist & sda_now;
            scl_rise <= scl_now & ~scl_hist;
            scl_fall <= ~scl_now & scl_hist;
            sda_bit  <= sda_now;
        end
    end

endmodule

// File: rtl/i2c_tgt2202.sv
// I2C target with a single 7-bit address. Writes deliver one byte at a
// time on o_rxdata/o_rx_valid; reads pull bytes from i_txdata with a
// o_tx_req handshake. SDA is only ever changed while SCL is low.
module i2c_tgt2202
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = DEFAULT_ADDR
) (
    input  logic       i_cclk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [7:0] i_txdata,
    input  logic       i_tx_valid,
    output logic       o_tx_req,
    output logic [7:0] o_rxdata,
    output logic       o_rx_valid,
    output logic       o_busy
);

    logic       start;
    logic       stop;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_bit;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx_shift;
    logic       rw;
    logic       ack_seen;

    logic [7:0] shifted;
    logic [7:0] next_byte;

    i2c_tgt_sync u_sync (
        .clk      (i_cclk),
        .rst_n    (i_rst_n),
        .scl      (i_scl),
        .sda      (i_sda),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_bit  (sda_bit)
    );

    // Byte assembled from the seven bits so far plus the bit on this SCL rise
    assign shifted   = {shift, sda_bit};
    assign next_byte = tx_pick(i_tx_valid, i_txdata);

    // Protocol FSM with bit counter, shift registers and registered outputs
    always_ff @(posedge i_cclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            tx_shift   <= 7'd0;
            rw         <= 1'b0;
            ack_seen   <= 1'b0;
            o_sda_oe   <= 1'b0;
            o_tx_req   <= 1'b0;
            o_rxdata   <= 8'h00;
            o_rx_valid <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle and are raised only in the
            // branch that produces them, so they can never stretch.
            o_rx_valid <= 1'b0;
            o_tx_req   <= 1'b0;

            // Bus conditions outrank any SCL edge seen in the same cycle
            if (start) begin
                state    <= ST_ADDR;
                bit_cnt  <= 3'd0;
                shift    <= 7'd0;
                ack_seen <= 1'b0;
                o_sda_oe <= 1'b0;
            end else if (stop) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                ack_seen <= 1'b0;
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_WAIT_STOP: begin
                        // Only START/STOP matter here
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= shifted[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shifted[7:1] == TGT_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    rw     <= shifted[0];
                                    o_busy <= 1'b1;
                                end else begin
                                    state  <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        // First fall drives the ACK, second fall ends the ACK clock
                        if (scl_fall) begin
                            if (!o_sda_oe) begin
                                o_sda_oe <= 1'b1;
                            end else if (rw) begin
                                state    <= ST_TX;
                                bit_cnt  <= 3'd0;
                                tx_shift <= next_byte[6:0];
                                o_sda_oe <= ~next_byte[7];
                                o_tx_req <= 1'b1;
                            end else begin
                                state    <= ST_RX;
                                o_sda_oe <= 1'b0;
                            end
                        end
                    end

                    ST_RX: begin
                        if (scl_rise) begin
                            shift   <= shifted[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state      <= ST_RX_ACK;
                                o_rxdata   <= shifted;
                                o_rx_valid <= 1'b1;
                            end
                        end
                    end

                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!o_sda_oe) begin
                                o_sda_oe <= 1'b1;
                            end else begin
                                state    <= ST_RX;
                                o_sda_oe <= 1'b0;
                            end
                        end
                    end

                    ST_TX: begin
                        // Each fall moves to the next bit; after bit 0 the line is released
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                state    <= ST_TX_ACK;
                                bit_cnt  <= 3'd0;
                                ack_seen <= 1'b0;
                                o_sda_oe <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                o_sda_oe <= ~tx_shift[6];
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_bit) begin
                                state <= ST_WAIT_STOP;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen) begin
                            state    <= ST_TX;
                            bit_cnt  <= 3'd0;
                            ack_seen <= 1'b0;
                            tx_shift <= next_byte[6:0];
                            o_sda_oe <= ~next_byte[7];
                            o_tx_req <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        o_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_tgt2202.sv
// Self-checking bench for i2c_tgt2202: a bit-banged I2C controller on a
// wired-AND SDA line, directed scenarios plus randomized transactions
// whose expected outcomes come from transaction-level rules.
module tb_i2c_tgt2202;

    localparam logic [6:0] TGT = 7'h42;
    localparam int         Q   = 5;   // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] txdata = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_req;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor counters, written only by the monitor process
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         oe_cyc = 0;
    int         viol   = 0;
    logic       prev_rx = 1'b0;
    logic       prev_tx = 1'b0;

    assign sda_line = sda_c & ~sda_oe;

    i2c_tgt2202 #(.TGT_ADDR(TGT)) dut (
        .i_cclk     (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl_c),
        .i_sda      (sda_line),
        .o_sda_oe   (sda_oe),
        .i_txdata   (txdata),
        .i_tx_valid (tx_valid),
        .o_tx_req   (tx_req),
        .o_rxdata   (rxdata),
        .o_rx_valid (rx_valid),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    // Count pulses and drive cycles; flag overlapping or stretched pulses
    always @(negedge clk) begin
        if (rx_valid) rx_cnt++;
        if (tx_req)   tx_cnt++;
        if (sda_oe)   oe_cyc++;
        if ((rx_valid && tx_req) || (rx_valid && prev_rx) || (tx_req && prev_tx)) viol++;
        prev_rx = rx_valid;
        prev_tx = tx_req;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        repeat (Q) @(negedge clk);
    endtask

    // START from idle bus, or repeated START from SCL low
    task automatic bus_start();
        sda_c = 1'b1; tick();
        scl_c = 1'b1; tick();
        sda_c = 1'b0; tick();
        scl_c = 1'b0; tick();
    endtask

    task automatic bus_stop();
        sda_c = 1'b0; tick();
        scl_c = 1'b1; tick();
        sda_c = 1'b1; tick();
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_c = b;    tick();
        scl_c = 1'b1; tick();
        seen = sda_line;
        tick();
        scl_c = 1'b0; tick();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] last;
        logic [7:0] exp_rd;
        logic [6:0] a;
        logic       rw;
        logic       match;
        int         n;
        int         rx_b;
        int         tx_b;
        int         oe_b;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rxdata", rxdata, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0x42+W, 0xA5
        rx_b = rx_cnt;
        bus_start();
        write_byte({TGT, 1'b0}, ack);
        check("wr_addr_ack", ack, 1'b1);
        check("wr_busy", busy, 1'b1);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 1'b1);
        bus_stop();
        check("wr_rxdata", rxdata, 8'hA5);
        check("wr_rx_pulses", rx_cnt - rx_b, 1);
        check("wr_busy_after_stop", busy, 1'b0);

        // Read 0x42+R with 0x3C valid, controller ACK then NACK
        tx_b = tx_cnt;
        txdata = 8'h3C; tx_valid = 1'b1;
        bus_start();
        write_byte({TGT, 1'b1}, ack);
        check("rd_addr_ack", ack, 1'b1);
        read_byte(1'b0, d);
        check("rd_byte0", d, 8'h3C);
        read_byte(1'b1, d);
        check("rd_byte1", d, 8'h3C);
        check("rd_release_after_nack", sda_oe, 1'b0);
        bus_stop();
        check("rd_tx_pulses", tx_cnt - tx_b, 2);
        check("rd_busy_after_stop", busy, 1'b0);

        // Address mismatch 0x43+W, data 0x11
        rx_b = rx_cnt; oe_b = oe_cyc;
        bus_start();
        write_byte({7'h43, 1'b0}, ack);
        check("mm_addr_ack", ack, 1'b0);
        check("mm_busy", busy, 1'b0);
        write_byte(8'h11, ack);
        check("mm_data_ack", ack, 1'b0);
        bus_stop();
        check("mm_oe_cycles", oe_cyc - oe_b, 0);
        check("mm_rx_pulses", rx_cnt - rx_b, 0);

        // Repeated START: write 0x07, then read with nothing valid
        tx_valid = 1'b0; txdata = 8'h5E;
        bus_start();
        write_byte({TGT, 1'b0}, ack);
        write_byte(8'h07, ack);
        check("sr_wr_ack", ack, 1'b1);
        bus_start();
        write_byte({TGT, 1'b1}, ack);
        check("sr_rd_addr_ack", ack, 1'b1);
        read_byte(1'b1, d);
        check("sr_read_idle_byte", d, 8'hFF);
        bus_stop();
        check("sr_rxdata", rxdata, 8'h07);

        // Asynchronous reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            last = {TGT, 1'b0};
            clock_bit(last[i], s);
        end
        sda_c = 1'b1; tick();
        check("ack_driven_before_reset", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_release_oe", sda_oe, 1'b0);
        check("async_release_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scl_c = 1'b1; tick();

        // Reset during the 4th RX bit, then a full write of 0x5A
        rx_b = rx_cnt; tx_b = tx_cnt;
        bus_start();
        write_byte({TGT, 1'b0}, ack);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        sda_c = 1'b0; tick();
        scl_c = 1'b1; tick();
        rst_n = 1'b0;
        #1;
        check("midrx_reset_oe", sda_oe, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sda_c = 1'b1; tick();
        check("midrx_no_pulses", (rx_cnt - rx_b) + (tx_cnt - tx_b), 0);
        check("midrx_rxdata_cleared", rxdata, 8'h00);
        bus_start();
        write_byte({TGT, 1'b0}, ack);
        check("post_reset_addr_ack", ack, 1'b1);
        write_byte(8'h5A, ack);
        check("post_reset_data_ack", ack, 1'b1);
        bus_stop();
        check("post_reset_rxdata", rxdata, 8'h5A);
        check("post_reset_rx_pulses", rx_cnt - rx_b, 1);

        // Early STOP after 3 address bits
        rx_b = rx_cnt; tx_b = tx_cnt; oe_b = oe_cyc;
        bus_start();
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b0, s);
        bus_stop();
        check("early_stop_busy", busy, 1'b0);
        check("early_stop_oe_cycles", oe_cyc - oe_b, 0);
        check("early_stop_pulses", (rx_cnt - rx_b) + (tx_cnt - tx_b), 0);
        check("early_stop_rxdata", rxdata, 8'h5A);

        // Randomized transactions against transaction-level expectations
        for (int t = 0; t < 16; t++) begin
            a        = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
            rw       = 1'($urandom_range(0, 1));
            n        = $urandom_range(1, 3);
            tx_valid = 1'($urandom_range(0, 1));
            txdata   = 8'($urandom);
            match    = (a == TGT);
            exp_rd   = tx_valid ? txdata : 8'hFF;
            last     = rxdata;
            rx_b = rx_cnt; tx_b = tx_cnt; oe_b = oe_cyc;

            bus_start();
            write_byte({a, rw}, ack);
            check("rnd_addr_ack", ack, match);
            check("rnd_busy", busy, match);
            for (int k = 0; k < n; k++) begin
                if (match && rw) begin
                    read_byte(k == n - 1, d);
                    check("rnd_read_byte", d, exp_rd);
                end else begin
                    d = 8'($urandom);
                    write_byte(d, ack);
                    check("rnd_write_ack", ack, match);
                    if (match) last = d;
                end
            end
            bus_stop();
            check("rnd_busy_after_stop", busy, 1'b0);
            check("rnd_rx_pulses", rx_cnt - rx_b, (match && !rw) ? n : 0);
            check("rnd_tx_pulses", tx_cnt - tx_b, (match && rw) ? n : 0);
            check("rnd_rxdata", rxdata, last);
            if (!match) check("rnd_mismatch_oe_cycles", oe_cyc - oe_b, 0);
        end

        check("pulse_exclusive_single_cycle", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
